// File: rtl/tdm_mux4to1_if.sv
// Bus bundle for the 4-to-1 TDM multiplexer: four valid/ready source lanes
// on the input side and one tagged, registered word on the link side.
interface tdm_mux4to1_if #(
   parameter int WIDTH = 8
) ();

   logic [4*WIDTH-1:0] in_data;
   logic [3:0]         in_valid;
   logic [3:0]         in_ready;
   logic [WIDTH-1:0]   out_data;
   logic [1:0]         out_sel;
   logic               out_valid;
   logic               out_ready;

   // The master side supplies the lane words and sinks the link word.
   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_sel,
      input  out_valid,
      output out_ready
   );

   // The slave side is the multiplexer itself.
   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_sel,
      output out_valid,
      input  out_ready
   );

endinterface

// File: rtl/tdm_mux4to1.sv
// Round-robin 4-to-1 time-division multiplexer. Merges four valid/ready lanes
// onto one registered output word tagged with its lane index (out_sel), which
// drives the select of the far-end 1-to-4 demux.
// The WIDTH parameter must match the WIDTH of the connected interface.
module tdm_mux4to1 #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   tdm_mux4to1_if.slave bus
);

   logic [1:0]       r_ptr;
   logic [WIDTH-1:0] r_outData;
   logic [1:0]       r_outSel;
   logic             r_outValid;

   logic             w_loadable;
   logic             w_anyValid;
   logic             w_load;
   logic             w_found;
   logic [1:0]       w_idx;
   logic [1:0]       w_grant;
   logic [3:0]       w_inReady;
   logic [WIDTH-1:0] w_grantData;

   // The output register can take a new word when empty or being drained this
   // cycle; reset blocks loading so in_ready stays low while rst is high.
   assign w_loadable = !r_outValid || bus.out_ready;
   assign w_anyValid = |bus.in_valid;
   assign w_load     = w_loadable && w_anyValid && !rst;

   // Scan lanes starting at the priority pointer and grant the first valid one.
   always_comb begin
      w_grant = r_ptr;
      w_found = 1'b0;
      w_idx   = r_ptr;
      for (int i = 0; i < 4; i++) begin
         w_idx = r_ptr + 2'(i);
         if (!w_found && bus.in_valid[w_idx]) begin
            w_grant = w_idx;
            w_found = 1'b1;
         end
      end
   end

   // Pick the granted lane's word out of the packed input bus.
   always_comb begin
      w_grantData = bus.in_data[int'(w_grant) * WIDTH +: WIDTH];
   end

   // Ready goes only to the granted lane, and only when a load really happens.
   always_comb begin
      w_inReady = 4'b0000;
      if (w_load) begin
         w_inReady[w_grant] = 1'b1;
      end
   end

   // Output register and priority pointer; an idle loadable cycle only drops
   // out_valid so the last word and tag stay visible on the link.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outSel   <= 2'd0;
         r_ptr      <= 2'd0;
      end else if (w_load) begin
         r_outValid <= 1'b1;
         r_outData  <= w_grantData;
         r_outSel   <= w_grant;
         r_ptr      <= w_grant + 2'd1;
      end else if (w_loadable) begin
         r_outValid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_inReady;
   assign bus.out_data  = r_outData;
   assign bus.out_sel   = r_outSel;
   assign bus.out_valid = r_outValid;

endmodule

// File: tb/tb_tdm_mux4to1.sv
// Directed bench for the round-robin 4-to-1 TDM multiplexer: reset, full
// rotation, backpressure, skip/wrap of the pointer, sparse traffic and a
// reset while a word is held.
module tb_tdm_mux4to1;

   localparam int WIDTH = 8;

   logic clk;
   logic rst;
   int   totalChecks;
   int   badChecks;

   tdm_mux4to1_if #(.WIDTH(WIDTH)) bus ();

   tdm_mux4to1 #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count one comparison and report it if it does not match.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive all inputs, let the combinational ready settle, then check it.
   task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [31:0] d,
                                input logic oRdy, input string tag, input logic [3:0] expReady);
      rst           = r;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = oRdy;
      #1;
      checkOutput(tag, {28'd0, bus.in_ready}, {28'd0, expReady});
   endtask

   // Advance one clock edge and check the registered output word.
   task automatic stepCheck(input string tag, input logic expValid, input logic [1:0] expSel,
                            input logic [7:0] expData);
      @(posedge clk);
      #1;
      checkOutput({tag, "Valid"}, {31'd0, bus.out_valid}, {31'd0, expValid});
      checkOutput({tag, "Sel"},   {30'd0, bus.out_sel},   {30'd0, expSel});
      checkOutput({tag, "Data"},  {24'd0, bus.out_data},  {24'd0, expData});
   endtask

   // Directed scenario sequence with hand-computed expectations.
   initial begin
      logic [31:0] allData;
      logic [31:0] bpData;
      logic [7:0]  rrData [4];
      totalChecks = 0;
      badChecks   = 0;
      allData     = 32'h44332211;
      rrData[0] = 8'h11; rrData[1] = 8'h22; rrData[2] = 8'h33; rrData[3] = 8'h44;

      // Reset held two cycles with every lane valid.
      applyStimulus(1'b1, 4'hF, allData, 1'b1, "rstReadyA", 4'b0000);
      @(posedge clk);
      stepCheck("rst", 1'b0, 2'd0, 8'h00);
      #1;
      checkOutput("rstReadyB", {28'd0, bus.in_ready}, 32'd0);

      // Full round-robin: grants 0,1,2,3,0,1,2,3 with no bubbles.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 4'hF, allData, 1'b1, "rrReady", 4'(1 << (i % 4)));
         stepCheck("rr", 1'b1, 2'(i % 4), rrData[i % 4]);
      end

      // Backpressure: lane 2 alone, then hold for three cycles.
      bpData = 32'h44A52211;
      applyStimulus(1'b0, 4'b0100, bpData, 1'b1, "bpLoadReady", 4'b0100);
      stepCheck("bpLoad", 1'b1, 2'd2, 8'hA5);
      for (int i = 0; i < 3; i++) begin
         // A new lane-2 word appears mid-hold; it must not be taken yet.
         if (i == 1) bpData = 32'h44B62211;
         applyStimulus(1'b0, 4'b0100, bpData, 1'b0, "bpHoldReady", 4'b0000);
         stepCheck("bpHold", 1'b1, 2'd2, 8'hA5);
      end
      // Release: accept the held word and load the next on the same edge.
      applyStimulus(1'b0, 4'b0100, bpData, 1'b1, "bpRelReady", 4'b0100);
      stepCheck("bpRel", 1'b1, 2'd2, 8'hB6);

      // Skip and wrap: pointer at 3, only lanes 1 and 3 valid.
      applyStimulus(1'b0, 4'b1010, allData, 1'b1, "skipReady3", 4'b1000);
      stepCheck("skip3", 1'b1, 2'd3, 8'h44);
      applyStimulus(1'b0, 4'b1010, allData, 1'b1, "skipReady1", 4'b0010);
      stepCheck("skip1", 1'b1, 2'd1, 8'h22);
      // Pointer now sits at 2, so an all-valid request would go to lane 2.
      applyStimulus(1'b0, 4'hF, allData, 1'b1, "ptrIsTwo", 4'b0100);

      // Sparse traffic: one lane-0 pulse, then idle.
      applyStimulus(1'b0, 4'b0001, 32'h4433225A, 1'b1, "sparseReady", 4'b0001);
      stepCheck("sparse", 1'b1, 2'd0, 8'h5A);
      applyStimulus(1'b0, 4'b0000, allData, 1'b1, "idleReady", 4'b0000);
      stepCheck("idleA", 1'b0, 2'd0, 8'h5A);
      stepCheck("idleB", 1'b0, 2'd0, 8'h5A);

      // Reset mid-operation while a lane-1 word is held.
      applyStimulus(1'b0, 4'b0010, allData, 1'b0, "midLoadReady", 4'b0010);
      stepCheck("midLoad", 1'b1, 2'd1, 8'h22);
      applyStimulus(1'b0, 4'b0000, allData, 1'b0, "midHoldReady", 4'b0000);
      stepCheck("midHold", 1'b1, 2'd1, 8'h22);
      applyStimulus(1'b1, 4'hF, allData, 1'b0, "midRstReady", 4'b0000);
      stepCheck("midRst", 1'b0, 2'd0, 8'h00);
      applyStimulus(1'b0, 4'hF, allData, 1'b1, "postRstReady", 4'b0001);
      stepCheck("postRst", 1'b1, 2'd0, 8'h11);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
